// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants and types for the round-robin mux-select arbiter.
package mux_arb_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: finds the first set request bit scanning upward from start, wrapping mod 4.
import mux_arb_pkg::*;
module rr_pick4 (
  input  logic [N_CH-1:0] req_masked,
  input  sel_t            start,
  output sel_t            pick,
  output logic            found
);
  always_comb begin
    pick  = start;
    found = |req_masked;
    for (int k = N_CH - 1; k >= 0; k--)
      if (req_masked[start + sel_t'(k)]) pick = start + sel_t'(k);
  end
endmodule

// File: rtl/mux_rr_sel_arb.sv
// mux_rr_sel_arb: round-robin arbiter driving the 4:1 mux sel, with a registered
// output slice, valid/ready handshake and a one-cycle ack back to the winner.
import mux_arb_pkg::*;
module mux_rr_sel_arb #(
  parameter int DATA_W = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH*DATA_W-1:0] data_in,
  output logic [N_CH-1:0]        ack,
  output sel_t                   sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data
);
  arb_state_t        state_q, state_d;
  sel_t              sel_q, sel_d, last_grant_q, last_grant_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [N_CH-1:0]   onehot_sel, pick_req;
  sel_t              pick_start, pick;
  logic              found, hs, load;
  rr_pick4 u_pick (
    .req_masked (pick_req),
    .start      (pick_start),
    .pick       (pick),
    .found      (found)
  );
  // The granted channel is masked in its ack cycle since it only drops req after seeing ack.
  always_comb begin
    onehot_sel   = N_CH'(1) << sel_q;
    hs           = out_valid_q & out_ready;
    ack          = hs ? onehot_sel : '0;
    pick_req     = (state_q == BUSY) ? (req & ~onehot_sel) : req;
    pick_start   = (state_q == BUSY) ? sel_q + sel_t'(1) : last_grant_q + sel_t'(1);
    load         = ((state_q == IDLE) | hs) & found;
    state_d      = load ? BUSY : ((state_q == BUSY) & ~hs) ? BUSY : IDLE;
    out_valid_d  = (state_d == BUSY);
    sel_d        = load ? pick : sel_q;
    out_data_d   = load ? data_in[int'(pick)*DATA_W +: DATA_W] : out_data_q;
    last_grant_d = hs ? sel_q : last_grant_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      last_grant_q <= sel_t'(N_CH - 1);
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end
  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_mux_rr_sel_arb.sv
// tb_mux_rr_sel_arb: directed checks of arbitration order, backpressure, re-grant and reset.
module tb_mux_rr_sel_arb;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] data_in = '0;
  logic [3:0] ack;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [0:0] out_data;
  int checks = 0;
  int errors = 0;
  mux_rr_sel_arb #(.DATA_W(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .ack       (ack),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic chk_all(input string tag, input logic v, input logic [1:0] s,
                         input logic d, input logic [3:0] a);
    chk({tag, ".valid"}, 8'(out_valid), 8'(v));
    chk({tag, ".sel"},   8'(sel),       8'(s));
    chk({tag, ".data"},  8'(out_data),  8'(d));
    chk({tag, ".ack"},   8'(ack),       8'(a));
  endtask
  initial begin
    // 1: idle after reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("t1_idle", 1'b0, 2'd0, 1'b0, 4'b0000);
    end
    // 2: single request, immediate accept
    data_in = 4'b1010; req = 4'b0001; out_ready = 1'b1;
    tick();
    chk_all("t2_grant", 1'b1, 2'd0, 1'b0, 4'b0001);
    req = 4'b0000;
    tick();
    chk("t2_drop.valid", 8'(out_valid), 8'd0);
    chk("t2_drop.ack", 8'(ack), 8'd0);
    // 3: all requesting, back-to-back rotation
    do_reset();
    data_in = 4'b1010; req = 4'b1111; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_all("t3_rr", 1'b1, 2'(i % 4), 1'(i % 2), 4'b0001 << (i % 4));
      tick();
    end
    req = 4'b0000;
    tick();
    // 4: backpressure holds the transfer
    do_reset();
    data_in = 4'b0101; req = 4'b0100; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk_all("t4_hold", 1'b1, 2'd2, 1'b1, 4'b0000);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk_all("t4_accept", 1'b1, 2'd2, 1'b1, 4'b0100);
    req = 4'b0000;
    tick();
    chk("t4_end.valid", 8'(out_valid), 8'd0);
    // 5: lone continuous requester gets every other cycle
    do_reset();
    data_in = 4'b0100; req = 4'b0100; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_all("t5_alt", 1'(i % 2 == 0), 2'd2, 1'b1, (i % 2 == 0) ? 4'b0100 : 4'b0000);
      tick();
    end
    // 6: reset mid-transfer
    do_reset();
    data_in = 4'b1010; req = 4'b1111; out_ready = 1'b1;
    tick();
    tick();
    chk_all("t6_pre", 1'b1, 2'd1, 1'b1, 4'b0010);
    rst_n = 1'b0;
    #1;
    chk_all("t6_rst", 1'b0, 2'd0, 1'b0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all("t6_after", 1'b1, 2'd0, 1'b0, 4'b0001);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_rr_sel_arb.md
Name: mux_rr_sel_arb

Overview:
- Upstream stage of the 4-to-1 mux.
- Arbitrates among four requesting channels with a round-robin policy and drives the 2-bit sel for the downstream mux_4to1_sv.
- Registers the selected channel's data slice into an output register with a valid/ready handshake.
- Returns a one-cycle ack to the channel whose data was accepted.

Parameters:
- DATA_W, 1: width of each channel's data slice. With the default, data_in is 4 bits, matching the mux.
- N_CH, 4: number of channels. Fixed at 4 for this revision. SEL_W = 2 is derived from it.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  per-channel request. Bit i held high until ack[i] is seen.
- data_in  input  4*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]. Must be stable while req[i] is high.
- ack  output  4  one-hot, one-cycle pulse. Marks the cycle in which channel sel's data is accepted downstream.
- sel  output  2  index of the granted channel. Registered; feeds the mux sel.
- out_valid  output  1  out_data/sel hold a granted transfer.
- out_ready  input  1  downstream accepts the current transfer.
- out_data  output  DATA_W  registered copy of the granted channel's slice.

Behaviour:
- Reset (async assert, sync release):
  - sel=2'b00, out_valid=0, out_data=0, ack=0, state=IDLE.
  - last_grant=2'b11, so channel 0 has first priority.
- States: IDLE, BUSY.
- IDLE:
  - If |req, pick the first set bit scanning last_grant+1, +2, +3, +4 (mod 4).
  - On the next edge: sel <= pick, out_data <= slice[pick], out_valid <= 1, state <= BUSY.
  - Latency from req to out_valid is 1 cycle.
  - If req==0, stay in IDLE with all outputs held.
- BUSY with out_valid & !out_ready (backpressure):
  - sel, out_data and out_valid held stable.
  - ack=0.
  - No re-arbitration.
- BUSY with out_valid & out_ready (handshake):
  - ack[sel]=1 combinationally in that cycle; ack is 0 in all other cycles.
  - last_grant <= sel.
  - Re-arbitrate in the same cycle on masked = req & ~onehot(sel), searching from sel+1.
  - If masked != 0: load the new pick on the next edge (back-to-back, one transfer per cycle), stay in BUSY.
  - Else: out_valid <= 0, state <= IDLE. sel and out_data retain their last values.
- The granted channel's req is masked in its ack cycle, because the requester drops req only after seeing ack.
  - A channel requesting continuously alone therefore gets 1 transfer every 2 cycles.
- If req[sel] drops while BUSY, the transfer still completes: the data is already captured.
- At most one ack bit is ever set. ack is never set while out_valid=0.
- sel wraps 3 -> 0 modulo 4. No other arithmetic.
- Reset asserted mid-transfer:
  - out_valid and ack go 0 immediately; the transfer is dropped with no ack.
  - Priority restarts at channel 0 after release.

Decomposition:
- Shared package mux_arb_pkg:
  - localparam N_CH=4, SEL_W=2.
  - typedef enum logic {IDLE, BUSY} arb_state_t.
  - typedef logic [SEL_W-1:0] sel_t.
- Sub-module rr_pick4 (combinational):
  - Inputs: req_masked[3:0], start index.
  - Outputs: pick (sel_t), found.
  - Instantiated once. Used in both IDLE and handshake re-arbitration.

Test Plan:
1. Reset, req=4'b0000 for 5 cycles -> out_valid=0, sel=2'b00, ack=4'b0000, out_data=0 throughout.
2. DATA_W=1, data_in=4'b1010, req=4'b0001, out_ready=1 -> next cycle out_valid=1, sel=00, out_data=0, ack=4'b0001. Then req=0 -> out_valid=0.
3. data_in=4'b1010, req=4'b1111 held (each bit dropped 1 cycle after its ack, then reasserted), out_ready=1:
   - grants sel=00,01,10,11,00 on consecutive cycles;
   - out_data=0,1,0,1,0;
   - ack one-hot matching sel.
4. data_in=4'b0101, req=4'b0100, out_ready=0 for 3 cycles then 1 -> sel=10 and out_data=1 stable for 4 cycles; ack=4'b0100 only on the 4th.
5. Only req[2] held continuously, out_ready=1 -> sel=10 granted every other cycle, out_valid toggles 1,0,1,0; no other ack bits.
6. req=4'b1111, pull rst_n low while BUSY with sel=01 -> out_valid=0 and ack=0 immediately. After release, first grant is sel=00.
